// File: rtl/uart_pkg.sv
// Shared constants, receiver state encoding and parity helper for the UART receiver.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 87;
  localparam int DATA_BITS_DEF    = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } rx_state_e;

  // Expected parity bit for a word zero-extended to the widest legal frame.
  function automatic logic calc_parity(input logic [8:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for the idle-high serial line; both flops reset to 1
// so that reset release never looks like a start bit.
module uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Double-register the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with ready/valid output and error pulses.
// Optional parity check is built only when UART_RX_PARITY_EN is defined.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = DATA_BITS_DEF,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_pin,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        BIT_LAST = 4'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 8 || CLKS_PER_BIT > 65535 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
    $error("uart_rx_cfg: parameter out of legal range");
  end

  logic                 rx_s;
  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 perr_q, perr_d;
`endif

  uart_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx_pin),
    .q_o   (rx_s)
  );

  // Frame sequencing, shift register and output handshake next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif

    if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = 4'd0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 4'd1;
          if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          par_bad_d = (rx_s != calc_parity(9'(shift_q), PARITY_ODD[0]));
          state_d   = ST_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      ST_STOP: begin
        // Leave STOP at the sample point so the next start edge is caught.
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (!rx_s) begin
            ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad_q) begin
            perr_d = 1'b1;
`endif
          end else if (valid_q && !rx_ready) begin
            ovr_d = 1'b1;
          end else begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counters, data and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= 4'd0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: frame table plus corner-case sequences,
// received words checked through an expected/observed scoreboard.
module tb_uart_rx_cfg;

  localparam int CPB = 87;
  localparam int DB  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_pin = 1'b1;
  logic          rx_ready = 1'b1;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          parity_err;
  logic          overrun;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_ODD(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_pin     (rx_pin),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  int acc_cnt  = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  int ovr_cnt  = 0;
  logic [DB-1:0] got_q[$];
  logic [DB-1:0] exp_q[$];

  // Monitor: records accepted words and counts error pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && rx_ready) begin
        acc_cnt = acc_cnt + 1;
        got_q.push_back(rx_data);
      end
      if (frame_err)  ferr_cnt = ferr_cnt + 1;
      if (parity_err) perr_cnt = perr_cnt + 1;
      if (overrun)    ovr_cnt  = ovr_cnt + 1;
    end
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       good;
  } vec_t;

  vec_t vecs[5];
  int a0, f0, p0, o0;
  logic [7:0] last_good;

  task automatic check(input string name, input int act, input int exp);
    n_cmp = n_cmp + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx_pin = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_pin = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`else
    if (par === 1'bx) rx_pin = 1'b1;
`endif
    drive_bit(stop);
  endtask

  task automatic snap();
    a0 = acc_cnt;
    f0 = ferr_cnt;
    p0 = perr_cnt;
    o0 = ovr_cnt;
  endtask

  task automatic check_deltas(input string name, input int acc, input int fe, input int pe, input int ov);
    check({name, "_valid"},  acc_cnt - a0, acc);
    check({name, "_ferr"},   ferr_cnt - f0, fe);
    check({name, "_perr"},   perr_cnt - p0, pe);
    check({name, "_ovr"},    ovr_cnt - o0, ov);
  endtask

  task automatic drain(input string name);
    check({name, "_sb_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      check({name, "_sb_data"}, int'(got_q.pop_front()), int'(exp_q.pop_front()));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b1};
    vecs[1] = '{8'h00, 1'b1, 1'b1};
    vecs[2] = '{8'hFF, 1'b1, 1'b1};
    vecs[3] = '{8'h3C, 1'b0, 1'b0};
    vecs[4] = '{8'h81, 1'b1, 1'b1};
    last_good = 8'h00;

    repeat (5) @(posedge clk);
    #1;
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_perr", parity_err, 0);
    check("rst_ovr", overrun, 0);
    rst_n = 1'b1;
    idle(20);

    // Frame table with the consumer always ready.
    for (int k = 0; k < 5; k++) begin
      snap();
      if (vecs[k].good) begin
        exp_q.push_back(vecs[k].data);
        last_good = vecs[k].data;
      end
      send_frame(vecs[k].data, vecs[k].stop, ^vecs[k].data);
      idle(20);
      check_deltas($sformatf("vec%0d", k), vecs[k].good ? 1 : 0, vecs[k].good ? 0 : 1, 0, 0);
      check($sformatf("vec%0d_data", k), rx_data, last_good);
      drain($sformatf("vec%0d", k));
    end

    // 30-cycle low glitch, then a clean frame to show the receiver is idle.
    snap();
    rx_pin = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    idle(150);
    check_deltas("glitch", 0, 0, 0, 0);
    check("glitch_valid", rx_valid, 0);
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1, ^8'h96);
    idle(20);
    check_deltas("post_glitch", 1, 0, 0, 0);
    drain("post_glitch");

    // Back-to-back frames with the consumer stalled.
    rx_ready = 1'b0;
    snap();
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, ^8'h11);
    check("ovr_first_ovr", ovr_cnt - o0, 0);
    check("ovr_first_valid", rx_valid, 1);
    send_frame(8'h22, 1'b1, ^8'h22);
    idle(20);
    check("ovr_valid", rx_valid, 1);
    check("ovr_data", rx_data, 8'h11);
    check_deltas("ovr", 0, 0, 0, 1);
    rx_ready = 1'b1;
    idle(3);
    check("ovr_valid_cleared", rx_valid, 0);
    drain("ovr");

    // Reset in the middle of data bit 3, then a clean frame.
    snap();
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(8'h5A >> i);
    rx_pin = (8'h5A >> 3) & 8'h01;
    repeat (CPB / 2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    rx_pin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_data", rx_data, 0);
    check("midrst_valid", rx_valid, 0);
    rst_n = 1'b1;
    idle(20);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, ^8'h5A);
    idle(20);
    check_deltas("midrst", 1, 0, 0, 0);
    check("midrst_data_after", rx_data, 8'h5A);
    drain("midrst");

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 needs parity bit 1.
    snap();
    send_frame(8'h07, 1'b1, 1'b0);
    idle(20);
    check_deltas("par_bad", 0, 0, 1, 0);
    check("par_bad_data", rx_data, 8'h5A);
    snap();
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    idle(20);
    check_deltas("par_good", 1, 0, 0, 0);
    drain("par_good");
`endif

    check("final_leftover", got_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, meaning clk cycles per bit period; the legal range SHALL be 8..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; the legal range SHALL be 5..9.
REQ-003 SHALL have parameter PARITY_ODD, default 0, meaning 0 = even parity and 1 = odd parity; it SHALL apply only when UART_RX_PARITY_EN is defined.
REQ-004 SHALL have port clk, input, 1, meaning system clock; all logic SHALL be on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning reset; it SHALL be asynchronous and active-low.
REQ-006 SHALL have port rx_pin, input, 1, meaning the asynchronous serial line, idle high.
REQ-007 SHALL have port rx_data, output, DATA_BITS, meaning the received word, LSB first on the line.
REQ-008 SHALL have port rx_valid, output, 1, meaning rx_data holds an unconsumed word.
REQ-009 SHALL have port rx_ready, input, 1, meaning the consumer accepts rx_data this cycle.
REQ-010 SHALL have port frame_err, output, 1, meaning a one-cycle pulse when a stop bit is sampled low.
REQ-011 SHALL have port parity_err, output, 1, meaning a one-cycle pulse when a parity mismatch is detected.
REQ-012 SHALL have port overrun, output, 1, meaning a one-cycle pulse when a completed word is dropped.

Function
REQ-013 SHALL pass rx_pin through a 2-flop synchroniser; all sampling SHALL use the synchronised value.
REQ-014 SHALL implement the states IDLE, START, DATA, PARITY and STOP.
REQ-015 In IDLE, a synchronised low SHALL move to START with the bit counter cleared.
REQ-016 In START, the line SHALL be resampled at count (CLKS_PER_BIT-1)/2; low SHALL move to DATA with the counter cleared, and high SHALL return to IDLE as a glitch with no flags.
REQ-017 In DATA, each bit SHALL be sampled at count CLKS_PER_BIT-1 and shifted in LSB first; after DATA_BITS samples the state SHALL move to PARITY if parity is enabled, else to STOP.
REQ-018 In PARITY, the bit SHALL be sampled at count CLKS_PER_BIT-1 and compared with the XOR of the data bits (inverted when PARITY_ODD=1).
REQ-019 In STOP, the line SHALL be sampled at count CLKS_PER_BIT-1, and the state SHALL return to IDLE on the same edge so that back-to-back frames are not missed.
REQ-020 When the stop bit is low, frame_err SHALL pulse, the word SHALL be discarded, and rx_valid SHALL be unchanged.
REQ-021 When parity is bad and the stop bit is good, parity_err SHALL pulse and the word SHALL be discarded.
REQ-022 A good frame SHALL load rx_data and assert rx_valid on the cycle after the stop sample.
REQ-023 rx_valid SHALL hold until a cycle with rx_valid and rx_ready both high, after which it SHALL clear on the next edge.
REQ-024 When a good frame completes while rx_valid=1 and rx_ready=0, overrun SHALL pulse, the new word SHALL be dropped, and the old rx_data SHALL be kept.
REQ-025 When a good frame completes in the same cycle as an accept, the new word SHALL load and rx_valid SHALL stay 1 with no overrun.
REQ-026 The bit counter SHALL be $clog2(CLKS_PER_BIT) bits wide and SHALL never wrap within a bit period.
REQ-027 rx_data SHALL change only on a good-frame load.

Reset
REQ-028 rst_n low SHALL force state IDLE, clear the counters and shift register, set rx_data=0 and rx_valid=0, clear all error pulses, and preset both synchroniser flops to 1.
REQ-029 Reset asserted mid-frame SHALL abandon the frame; after release, reception SHALL restart only on the next falling edge.

Configuration
REQ-030 Macro UART_RX_PARITY_EN SHALL control parity support.
REQ-031 With UART_RX_PARITY_EN defined, the PARITY state and parity check SHALL be present.
REQ-032 Without UART_RX_PARITY_EN, the PARITY state and its logic SHALL be absent, parity_err SHALL be tied to 0, and PARITY_ODD SHALL be ignored.

Structure
REQ-033 Package uart_pkg SHALL hold the rx state enum and default constants (CLKS_PER_BIT_DEF=87, DATA_BITS_DEF=8).
REQ-034 Sub-module uart_sync2 SHALL implement the reset-to-1 two-flop synchroniser; all other logic SHALL be in uart_rx_cfg.

Verification
REQ-035 With defaults and no parity, sending 0xA5 at 87 clks/bit with rx_ready=1 SHALL give rx_data=0xA5 with a one-cycle rx_valid pulse and no error flags.
REQ-036 A 30-cycle low glitch on an idle line SHALL produce no rx_valid, no flags, and a return to IDLE.
REQ-037 Sending 0x3C with the stop bit forced low SHALL pulse frame_err once, produce no rx_valid, and leave rx_data at its prior value.
REQ-038 Sending 0x11 then 0x22 back-to-back with rx_ready=0 SHALL leave rx_valid=1 and rx_data=0x11 and pulse overrun once, on the second frame.
REQ-039 With parity enabled and PARITY_ODD=0, sending 0x07 with parity bit 0 SHALL pulse parity_err and produce no rx_valid, and 0x07 with parity bit 1 SHALL be accepted.
REQ-040 With rst_n pulsed low at mid-frame during data bit 3, followed by a clean 0x5A frame, SHALL produce only rx_data=0x5A and no flags.
